// File: rtl/qc_pkg.sv
// Shared types and widths for the gate-times-state sequencer.
// complexNum is the signed 16-bit fixed-point complex sample.
package qc_pkg;

  typedef struct packed {
    logic signed [15:0] a;
    logic signed [15:0] b;
  } complexNum;

  localparam int FRAC       = 14;
  localparam int PROD_W     = 32;
  localparam int ACC_BASE_W = 34;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    FINISH
  } seqState;

  // Accumulator width that holds MAX = 2**n complex products without overflow.
  function automatic int accWidth(input int n);
    return ACC_BASE_W + n;
  endfunction

endpackage

// File: rtl/complex_mac.sv
// Shared complex multiply-accumulate: one product per valid read beat,
// result is the accumulator shifted down by FRAC and saturated per component.
module complex_mac
  import qc_pkg::*;
#(
  parameter int N    = 3,
  parameter int FRAC = qc_pkg::FRAC
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      issue,
  input  complexNum gateData,
  input  complexNum stateData,
  output complexNum result,
  output logic      resultSat
);

  localparam int ACC_W = accWidth(N);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic                     rdValid;
  logic signed [PROD_W-1:0] pAA, pBB, pAB, pBA;
  logic signed [ACC_W-1:0]  term [2];
  logic signed [ACC_W-1:0]  acc  [2];
  logic signed [15:0]       comp [2];
  logic [1:0]               compSat;

  assign pAA = PROD_W'($signed(gateData.a)) * PROD_W'($signed(stateData.a));
  assign pBB = PROD_W'($signed(gateData.b)) * PROD_W'($signed(stateData.b));
  assign pAB = PROD_W'($signed(gateData.a)) * PROD_W'($signed(stateData.b));
  assign pBA = PROD_W'($signed(gateData.b)) * PROD_W'($signed(stateData.a));

  assign term[0] = ACC_W'(pAA) - ACC_W'(pBB);
  assign term[1] = ACC_W'(pAB) + ACC_W'(pBA);

  // Read data is only trusted on the beat following an issued read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdValid <= 1'b0;
      acc[0]  <= '0;
      acc[1]  <= '0;
    end else begin
      rdValid <= issue;
      if (clear) begin
        acc[0] <= '0;
        acc[1] <= '0;
      end else if (rdValid) begin
        for (int i = 0; i < 2; i++) begin
          acc[i] <= acc[i] + term[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [ACC_W-1:0] shifted;
    logic                    hi;
    logic                    lo;

    assign shifted     = acc[gi] >>> FRAC;
    assign hi          = shifted > SAT_MAX;
    assign lo          = shifted < SAT_MIN;
    assign compSat[gi] = hi | lo;
    assign comp[gi]    = hi ? 16'sh7FFF : (lo ? 16'sh8000 : shifted[15:0]);
  end

  assign result.a  = comp[0];
  assign result.b  = comp[1];
  assign resultSat = |compSat;

endmodule

// File: rtl/gate_mult_sequencer.sv
// Sequences out[r] = sum_c gate[r][c]*state[c] through one shared complex MAC:
// per row, MAX read beats, one drain beat for the last read, one write beat.
module gate_mult_sequencer
  import qc_pkg::*;
#(
  parameter int N    = 3,
  parameter int MAX  = 2**N,
  parameter int FRAC = qc_pkg::FRAC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         sat,
  output logic [N-1:0] gate_row,
  output logic [N-1:0] gate_col,
  output logic         gate_rd,
  input  complexNum    gate_data,
  output logic [N-1:0] state_idx,
  input  complexNum    state_data,
  output logic         out_we,
  output logic [N-1:0] out_idx,
  output complexNum    out_data
);

  localparam logic [N-1:0] LAST = N'(MAX - 1);

  seqState      state, stateNext;
  logic [N-1:0] row, rowNext;
  logic [N-1:0] col, colNext;
  logic         macClear;
  logic         resultSat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= stateNext;
      row   <= rowNext;
      col   <= colNext;
      if (state == IDLE && start) begin
        sat <= 1'b0;
      end else if (out_we && resultSat) begin
        sat <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    rowNext   = row;
    colNext   = col;
    busy      = 1'b1;
    done      = 1'b0;
    gate_rd   = 1'b0;
    out_we    = 1'b0;
    macClear  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          macClear  = 1'b1;
          rowNext   = '0;
          colNext   = '0;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        gate_rd = 1'b1;
        if (col == LAST) begin
          stateNext = DRAIN;
        end else begin
          colNext = col + 1'b1;
        end
      end
      DRAIN: begin
        stateNext = WRITE;
      end
      // The output is taken from the MAC this cycle, so clearing on the same edge is safe.
      WRITE: begin
        out_we   = 1'b1;
        macClear = 1'b1;
        if (row == LAST) begin
          stateNext = FINISH;
        end else begin
          rowNext   = row + 1'b1;
          colNext   = '0;
          stateNext = ISSUE;
        end
      end
      FINISH: begin
        done      = 1'b1;
        busy      = 1'b0;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign gate_row  = row;
  assign gate_col  = col;
  assign state_idx = col;
  assign out_idx   = row;

  complex_mac #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (macClear),
    .issue     (gate_rd),
    .gateData  (gate_data),
    .stateData (state_data),
    .result    (out_data),
    .resultSat (resultSat)
  );

endmodule

// File: doc/gate_mult_sequencer.md
GATE_MULT_SEQUENCER -- requirements
Module: gate_mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 3, number of qubits.
REQ-002 SHALL have parameter MAX, default 2**N, state vector length and gate side.
REQ-003 SHALL have parameter FRAC, default 14, fraction bits of the signed 16-bit fixed-point format (1.0 = 0x4000).
REQ-004 SHALL have ports (clock and reset first):
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one gate*state product; sampled in IDLE only.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last output element is written.
- sat  output  1  sticky flag: some element saturated during the current run.
- gate_row, gate_col  output  N each  gate read address.
- gate_rd  output  1  gate read strobe.
- gate_data  input  complexNum (32)  gate[gate_row][gate_col], valid 1 cycle after gate_rd.
- state_idx  output  N  state read address; equals gate_col.
- state_data  input  complexNum (32)  state[state_idx], valid 1 cycle after gate_rd.
- out_we  output  1  output write strobe.
- out_idx  output  N  output element index.
- out_data  output  complexNum (32)  output element value (.a real, .b imag).

Function
REQ-005 SHALL compute out[r] = sum over c of gate[r][c]*state[c] for r = 0..MAX-1 using one shared complex multiply-accumulate unit, time-multiplexed.
REQ-006 SHALL implement FSM states IDLE, ISSUE, DRAIN, WRITE, FINISH.
REQ-007 IDLE: start=1 SHALL clear accumulator, row=0, col=0, sat=0 and move to ISSUE; start=0 stays IDLE.
REQ-008 ISSUE: SHALL assert gate_rd with gate_row=row, gate_col=col, one column per cycle; at col=MAX-1 move to DRAIN, else col+1.
REQ-009 DRAIN: SHALL last-accumulate the column-MAX-1 data and move to WRITE; gate_rd=0.
REQ-010 WRITE: SHALL assert out_we for exactly one cycle with out_idx=row; then if row=MAX-1 move to FINISH, else row+1, col=0, accumulator cleared, back to ISSUE.
REQ-011 FINISH: SHALL pulse done for one cycle, deassert busy in the same cycle, return to IDLE.
REQ-012 Each row SHALL take MAX+2 cycles; done SHALL assert exactly 1+MAX*(MAX+2) cycles after the accepting start edge (81 for N=3).
REQ-013 Complex product: real = ga*sa - gb*sb, imag = ga*sb + gb*sa, 32-bit signed products, accumulated in 34+N-bit signed registers without overflow.
REQ-014 Output element SHALL be accumulator arithmetic-shifted right by FRAC (truncation), then saturated to [-32768, 32767] per component; any saturation SHALL set sat.
REQ-015 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored; start in the IDLE cycle after done SHALL be accepted.
REQ-016 Read data arriving with no outstanding gate_rd SHALL not affect the accumulator.

Reset
REQ-017 reset=1 SHALL asynchronously force IDLE, row=col=0, accumulator=0, and busy, done, sat, gate_rd, out_we, gate_row, gate_col, out_idx, out_data all 0.
REQ-018 reset asserted mid-run SHALL abandon the run with no further out_we or done; the next start begins a fresh run from row 0.

Structure
REQ-019 complexNum (16-bit signed .a, .b), FRAC, and the product/accumulator width constants SHALL live in the shared package qc_pkg.
REQ-020 The multiply-accumulate datapath (clear, accumulate-enable, shift, saturate) SHALL be a sub-module named complex_mac; gate_mult_sequencer holds the FSM and counters only.

Verification
REQ-021 Identity gate (diagonal 0x4000), state[c]={c*0x100, -c*0x10} -> out equals state exactly, done at cycle 81, sat=0.
REQ-022 N=1, gate all 0x2D41 (~1/sqrt2), state={0x4000,0},{0,0} -> out[0]=out[1]={0x2D41,0}.
REQ-023 Gate all {0x7FFF,0}, state all {0x7FFF,0} -> every out.a=0x7FFF, out.b=0, sat=1 at done.
REQ-024 Imaginary check: gate[0][0]={0,0x4000}, others 0, state[0]={0x1000,0x2000} -> out[0]={-0x2000,0x1000}, out[1..]=0.
REQ-025 start pulsed at cycles 5 and 40 of a run -> only one done, at cycle 81; start in IDLE right after done -> second run, second done 82 cycles after the first.
REQ-026 reset asserted at cycle 30 -> all outputs 0 immediately; no out_we or done until a new start, which then completes normally.
